// File: rtl/glb_read_arbiter.sv
// Round-robin read arbiter for the global buffer: one owner at a time, bursts of up to
// MAX_BURST beats while others wait, a one-cycle bubble on every ownership change.
module glb_read_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_BURST  = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic                          glb_busy,
  output logic                          glb_re,
  output logic [ADDR_WIDTH-1:0]         glb_addr,
  input  logic [DATA_WIDTH-1:0]         glb_rdata,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic [NUM_REQ-1:0]            rvalid,
  output logic                          dbg_state,
  output logic [$clog2(MAX_BURST):0]    dbg_cnt
);

  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_BURST) + 1;

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

  // Handshake: gnt[i] is a one-cycle accept; a beat is consumed in the cycle gnt[i] is high,
  // and its data returns on rdata with rvalid[i] exactly one cycle later.

  state_t           state, state_n;
  logic [OW-1:0]    owner, owner_n;
  logic [OW-1:0]    ptr, ptr_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [OW-1:0]    pick, ptr_inc;
  logic             found, others, beat;
  logic [NUM_REQ-1:0] owner_mask;
  int               idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      owner  <= '0;
      ptr    <= '0;
      cnt    <= '0;
      rvalid <= '0;
    end else begin
      state  <= state_n;
      owner  <= owner_n;
      ptr    <= ptr_n;
      cnt    <= cnt_n;
      rvalid <= beat ? owner_mask : '0;
    end
  end

  always_comb begin
    state_n  = state;
    owner_n  = owner;
    ptr_n    = ptr;
    cnt_n    = cnt;
    gnt      = '0;
    glb_re   = 1'b0;
    glb_addr = '0;
    beat     = 1'b0;
    owner_mask        = '0;
    owner_mask[owner] = 1'b1;
    others   = |(req & ~owner_mask);
    ptr_inc  = (int'(owner) == NUM_REQ - 1) ? '0 : owner + 1'b1;
    // Cyclic first-set search starting at ptr.
    pick     = ptr;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = OW'(idx);
      end
    end
    case (state)
      IDLE: begin
        if (found && !glb_busy) begin
          state_n = OWN;
          owner_n = pick;
          cnt_n   = '0;
        end
      end
      OWN: begin
        glb_addr = req_addr[owner*ADDR_WIDTH +: ADDR_WIDTH];
        // A dropped request releases even while the GLB is busy.
        if (!req[owner]) begin
          state_n = IDLE;
          ptr_n   = ptr_inc;
        end else if (!glb_busy) begin
          beat   = 1'b1;
          gnt    = owner_mask;
          glb_re = 1'b1;
          if (cnt == CW'(MAX_BURST - 1)) begin
            cnt_n = '0;
            if (others) begin
              state_n = IDLE;
              ptr_n   = ptr_inc;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign rdata     = glb_rdata;
  assign dbg_state = state;
  assign dbg_cnt   = cnt;

endmodule

// File: doc/glb_read_arbiter.md
GLB_READ_ARBITER -- requirements
Module: glb_read_arbiter

Interface
REQ-001 The module SHALL have parameter NUM_REQ, default 3, giving the number of requesters (0 ifmap, 1 filter, 2 ipsum).
REQ-002 The module SHALL have parameter ADDR_WIDTH, default 20, giving the GLB address width.
REQ-003 The module SHALL have parameter DATA_WIDTH, default 16, giving the GLB read data width.
REQ-004 The module SHALL have parameter MAX_BURST, default 8, giving the maximum accepted beats per ownership while another requester waits (at least 1).
REQ-005 The module SHALL have a single clock; reset is synchronous and active-high.
REQ-006 The module SHALL have these ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- req  in  NUM_REQ  per-requester read request, level.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- gnt  out  NUM_REQ  one-hot beat accept; the beat is consumed in the cycle it is high.
- glb_busy  in  1  GLB write in progress; no reads are issued while high.
- glb_re  out  1  GLB read enable.
- glb_addr  out  ADDR_WIDTH  GLB read address.
- glb_rdata  in  DATA_WIDTH  GLB read data, valid one cycle after glb_re.
- rdata  out  DATA_WIDTH  glb_rdata passed straight through to all requesters.
- rvalid  out  NUM_REQ  one-hot; marks rdata for requester i.

Function
REQ-007 The arbiter SHALL have two states, IDLE and OWN, plus these registers:
- owner, width clog2(NUM_REQ).
- round-robin pointer ptr.
- burst counter cnt, width clog2(MAX_BURST)+1.
REQ-008 In IDLE with at least one req high and glb_busy low, the arbiter SHALL pick the first requester with req high, searching cyclically from ptr. Next cycle: state OWN, owner set to that requester, cnt set to 0.
REQ-009 In IDLE, gnt SHALL be 0 and glb_re SHALL be 0. The arbitration cycle is a bubble with no beat.
REQ-010 In OWN, the arbiter SHALL drive gnt[owner] = glb_re = req[owner] & ~glb_busy. All other gnt bits SHALL be 0.
REQ-011 glb_addr SHALL equal the owner's req_addr slice in OWN and SHALL be 0 in IDLE.
REQ-012 Each accepted beat (glb_re high) SHALL increment cnt. While glb_busy is high, cnt, owner and state SHALL hold.
REQ-013 In OWN, when req[owner] is low, the arbiter SHALL release ownership in that cycle: no beat, next state IDLE, ptr set to (owner+1) mod NUM_REQ.
REQ-014 In OWN, when a beat is accepted with cnt = MAX_BURST-1 and any other req bit is high, the arbiter SHALL release: next state IDLE, ptr set to (owner+1) mod NUM_REQ.
REQ-015 If that MAX_BURST beat occurs with no other req bit high, the arbiter SHALL keep ownership and reset cnt to 0.
REQ-016 rvalid SHALL be registered: rvalid[i] is high in cycle t+1 exactly when glb_re was high with owner i in cycle t.
REQ-017 rdata SHALL equal glb_rdata combinationally; the read-to-rvalid latency is exactly 1 cycle.
REQ-018 At most one gnt bit and at most one rvalid bit SHALL be high in any cycle.
REQ-019 Requests from non-owners that arrive while in OWN SHALL wait with no grant and no loss of the request.
REQ-020 glb_busy rising in the same cycle as a release condition SHALL NOT block the release; the release still takes effect.

Reset
REQ-021 While reset is high at a clock edge, the arbiter SHALL set state IDLE, owner 0, ptr 0 and cnt 0.
REQ-022 In the cycle after reset, gnt, glb_re, glb_addr and rvalid SHALL all be 0.
REQ-023 A reset during a burst SHALL abandon the burst; the in-flight beat's rvalid SHALL be suppressed.

Verification
REQ-024 Single requester: req=3'b010 held, addr=0x00100, MAX_BURST=8.
- Required: cycle 1 is the bubble.
- Then gnt[1] and glb_re are high every cycle with glb_addr=0x00100.
- rvalid[1] follows one cycle later, and ownership is retained past 8 beats.
REQ-025 Contention: req=3'b111 held from reset.
- Required: owner 0 gets 8 beats, then 1 bubble.
- Then owner 1 gets 8 beats, then owner 2, then owner 0 again.
- Strict rotation, and never two gnt bits high.
REQ-026 Early release: owner 2 drops req after 3 beats while req[0] is high.
- Required: the next cycle is IDLE.
- Owner 0 is then granted, since ptr=0.
- Exactly 3 rvalid[2] pulses.
REQ-027 glb_busy high for 4 cycles mid-burst, after 5 beats by owner 1.
- Required: glb_re=0 and gnt=0 for those 4 cycles, and cnt holds at 5.
- After glb_busy drops, owner 1 gets 3 more beats, then releases to a waiting requester.
REQ-028 Reset asserted in the cycle after a beat.
- Required: the following cycle has rvalid=0, gnt=0 and glb_re=0.
- After reset drops, arbitration starts from ptr=0.
